// File: rtl/pipe_pkg.sv
// Shared definitions for the ID/EX pipeline slice: ALU codes, id_ctrl layout and the bubble control word.
package pipe_pkg;

   localparam logic [3:0] ALU_AND = 4'b0000;
   localparam logic [3:0] ALU_OR  = 4'b0001;
   localparam logic [3:0] ALU_ADD = 4'b0010;
   localparam logic [3:0] ALU_SUB = 4'b0110;
   localparam logic [3:0] ALU_SLT = 4'b0111;
   localparam logic [3:0] ALU_NOR = 4'b1100;

   // id_ctrl = {alusrc, alucontrol[3:0], regdst, memread, memwrite, regwrite, memtoreg}
   localparam int CTRL_W        = 10;
   localparam int CTRL_ALUSRC   = 9;
   localparam int CTRL_ALUC_LSB = 5;
   localparam int CTRL_REGDST   = 4;
   localparam int CTRL_MEMREAD  = 3;
   localparam int CTRL_MEMWRITE = 2;
   localparam int CTRL_REGWRITE = 1;
   localparam int CTRL_MEMTOREG = 0;

   typedef struct packed {
      logic       alusrc;
      logic [3:0] alucontrol;
      logic       memread;
      logic       memwrite;
      logic       regwrite;
      logic       memtoreg;
   } ex_ctrl_t;

   localparam ex_ctrl_t BUBBLE_CTRL = '{alusrc: 1'b0, alucontrol: ALU_ADD, memread: 1'b0,
                                        memwrite: 1'b0, regwrite: 1'b0, memtoreg: 1'b0};

   function automatic ex_ctrl_t ctrl_from_id(input logic [CTRL_W-1:0] c);
      ex_ctrl_t r;
      r.alusrc     = c[CTRL_ALUSRC];
      r.alucontrol = c[CTRL_ALUC_LSB +: 4];
      r.memread    = c[CTRL_MEMREAD];
      r.memwrite   = c[CTRL_MEMWRITE];
      r.regwrite   = c[CTRL_REGWRITE];
      r.memtoreg   = c[CTRL_MEMTOREG];
      return r;
   endfunction

endpackage

// File: rtl/fwd_unit.sv
// EX operand forwarding: picks EX/MEM result, MEM/WB data or the registered regfile value per operand.
module fwd_unit #(
   parameter int XLEN = 32,
   parameter int REGW = 5
) (
   input  logic [REGW-1:0] ex_rs_i,
   input  logic [REGW-1:0] ex_rt_i,
   input  logic [XLEN-1:0] read1_i,
   input  logic [XLEN-1:0] read2_i,
   input  logic            mem_regwrite_i,
   input  logic [REGW-1:0] mem_rd_i,
   input  logic [XLEN-1:0] mem_result_i,
   input  logic            wb_regwrite_i,
   input  logic [REGW-1:0] wb_rd_i,
   input  logic [XLEN-1:0] wb_data_i,
   output logic [XLEN-1:0] data1_o,
   output logic [XLEN-1:0] read2_o
);

   // EX/MEM is younger than MEM/WB, so it wins; $0 is hardwired and never forwarded.
   function automatic logic [XLEN-1:0] pick(input logic [REGW-1:0] src, input logic [XLEN-1:0] regval);
      if (mem_regwrite_i && (mem_rd_i != '0) && (mem_rd_i == src))
         return mem_result_i;
      else if (wb_regwrite_i && (wb_rd_i != '0) && (wb_rd_i == src))
         return wb_data_i;
      else
         return regval;
   endfunction

   always_comb begin
      data1_o = pick(ex_rs_i, read1_i);
      read2_o = pick(ex_rt_i, read2_i);
   end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use stall detection, bubble insertion,
// EX operand forwarding and a saturating stall-cycle counter.
module id_ex_stage
   import pipe_pkg::*;
#(
   parameter int XLEN = 32,
   parameter int REGW = 5,
   parameter int CNTW = 16
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              id_valid,
   input  logic [XLEN-1:0]   id_pc4,
   input  logic [31:0]       id_instru,
   input  logic [XLEN-1:0]   id_read1,
   input  logic [XLEN-1:0]   id_read2,
   input  logic [REGW-1:0]   id_rs,
   input  logic [REGW-1:0]   id_rt,
   input  logic [REGW-1:0]   id_rd,
   input  logic [CTRL_W-1:0] id_ctrl,
   input  logic              id_uses_rt,
   input  logic              flush,
   input  logic              mem_regwrite,
   input  logic [REGW-1:0]   mem_rd,
   input  logic [XLEN-1:0]   mem_result,
   input  logic              wb_regwrite,
   input  logic [REGW-1:0]   wb_rd,
   input  logic [XLEN-1:0]   wb_data,
   output logic              stall_o,
   output logic              ex_valid,
   output logic [XLEN-1:0]   ex_pc4,
   output logic [31:0]       ex_instru,
   output logic [XLEN-1:0]   ex_data1,
   output logic [XLEN-1:0]   ex_read2,
   output logic              ex_alusrc,
   output logic [3:0]        ex_alucontrol,
   output logic [REGW-1:0]   ex_writereg,
   output logic              ex_memread,
   output logic              ex_memwrite,
   output logic              ex_regwrite,
   output logic              ex_memtoreg,
   output logic [CNTW-1:0]   stall_cnt
);

   logic            valid_q,    valid_d;
   logic [XLEN-1:0] pc4_q,      pc4_d;
   logic [31:0]     instru_q,   instru_d;
   logic [XLEN-1:0] read1_q,    read1_d;
   logic [XLEN-1:0] read2_q,    read2_d;
   logic [REGW-1:0] rs_q,       rs_d;
   logic [REGW-1:0] rt_q,       rt_d;
   logic [REGW-1:0] writereg_q, writereg_d;
   ex_ctrl_t        ctrl_q,     ctrl_d;
   logic [CNTW-1:0] cnt_q,      cnt_d;

   // Load in EX whose destination is a source of the ID instruction.
   assign stall_o = valid_q && ctrl_q.memread && (writereg_q != '0) && id_valid &&
                    ((writereg_q == id_rs) || (id_uses_rt && (writereg_q == id_rt)));

   always_comb begin
      valid_d    = 1'b0;
      pc4_d      = '0;
      instru_d   = '0;
      read1_d    = '0;
      read2_d    = '0;
      rs_d       = '0;
      rt_d       = '0;
      writereg_d = '0;
      ctrl_d     = BUBBLE_CTRL;
      if (!flush && !stall_o) begin
         valid_d  = id_valid;
         pc4_d    = id_pc4;
         instru_d = id_instru;
         read1_d  = id_read1;
         read2_d  = id_read2;
         rs_d     = id_rs;
         rt_d     = id_rt;
         if (id_valid) begin
            ctrl_d     = ctrl_from_id(id_ctrl);
            writereg_d = id_ctrl[CTRL_REGDST] ? id_rd : id_rt;
         end else begin
            ctrl_d = '0;
         end
      end
   end

   always_comb begin
      cnt_d = cnt_q;
      if (stall_o && !flush && (cnt_q != '1))
         cnt_d = cnt_q + 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q    <= 1'b0;
         pc4_q      <= '0;
         instru_q   <= '0;
         read1_q    <= '0;
         read2_q    <= '0;
         rs_q       <= '0;
         rt_q       <= '0;
         writereg_q <= '0;
         ctrl_q     <= '0;
         cnt_q      <= '0;
      end else begin
         valid_q    <= valid_d;
         pc4_q      <= pc4_d;
         instru_q   <= instru_d;
         read1_q    <= read1_d;
         read2_q    <= read2_d;
         rs_q       <= rs_d;
         rt_q       <= rt_d;
         writereg_q <= writereg_d;
         ctrl_q     <= ctrl_d;
         cnt_q      <= cnt_d;
      end
   end

   fwd_unit #(.XLEN(XLEN), .REGW(REGW)) u_fwd (
      .ex_rs_i        (rs_q),
      .ex_rt_i        (rt_q),
      .read1_i        (read1_q),
      .read2_i        (read2_q),
      .mem_regwrite_i (mem_regwrite),
      .mem_rd_i       (mem_rd),
      .mem_result_i   (mem_result),
      .wb_regwrite_i  (wb_regwrite),
      .wb_rd_i        (wb_rd),
      .wb_data_i      (wb_data),
      .data1_o        (ex_data1),
      .read2_o        (ex_read2)
   );

   assign ex_valid      = valid_q;
   assign ex_pc4        = pc4_q;
   assign ex_instru     = instru_q;
   assign ex_alusrc     = ctrl_q.alusrc;
   assign ex_alucontrol = ctrl_q.alucontrol;
   assign ex_writereg   = writereg_q;
   assign ex_memread    = ctrl_q.memread;
   assign ex_memwrite   = ctrl_q.memwrite;
   assign ex_regwrite   = ctrl_q.regwrite;
   assign ex_memtoreg   = ctrl_q.memtoreg;
   assign stall_cnt     = cnt_q;

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed vector table, async reset, counter saturation, and randomized
// traffic checked against a behavioural model of the pipeline slot.
module tb_id_ex_stage;

   localparam logic [9:0] C_ADD  = 10'h052;
   localparam logic [9:0] C_LW   = 10'h24B;
   localparam logic [9:0] C_ADDI = 10'h242;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        id_valid, id_uses_rt, flush;
   logic [31:0] id_pc4, id_instru, id_read1, id_read2;
   logic [4:0]  id_rs, id_rt, id_rd;
   logic [9:0]  id_ctrl;
   logic        mem_regwrite, wb_regwrite;
   logic [4:0]  mem_rd, wb_rd;
   logic [31:0] mem_result, wb_data;

   logic        stall_o, ex_valid, ex_alusrc, ex_memread, ex_memwrite, ex_regwrite, ex_memtoreg;
   logic [31:0] ex_pc4, ex_instru, ex_data1, ex_read2;
   logic [3:0]  ex_alucontrol;
   logic [4:0]  ex_writereg;
   logic [15:0] stall_cnt;

   logic        s_stall_o, s_ex_valid, s_ex_alusrc, s_ex_memread, s_ex_memwrite, s_ex_regwrite, s_ex_memtoreg;
   logic [31:0] s_ex_pc4, s_ex_instru, s_ex_data1, s_ex_read2;
   logic [3:0]  s_ex_alucontrol;
   logic [4:0]  s_ex_writereg;
   logic [3:0]  s_stall_cnt;

   int checks = 0;
   int errors = 0;
   int tag    = 0;

   always #5 clk = ~clk;

   id_ex_stage dut (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc4(id_pc4), .id_instru(id_instru),
      .id_read1(id_read1), .id_read2(id_read2), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
      .id_ctrl(id_ctrl), .id_uses_rt(id_uses_rt), .flush(flush),
      .mem_regwrite(mem_regwrite), .mem_rd(mem_rd), .mem_result(mem_result),
      .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_data(wb_data),
      .stall_o(stall_o), .ex_valid(ex_valid), .ex_pc4(ex_pc4), .ex_instru(ex_instru),
      .ex_data1(ex_data1), .ex_read2(ex_read2), .ex_alusrc(ex_alusrc), .ex_alucontrol(ex_alucontrol),
      .ex_writereg(ex_writereg), .ex_memread(ex_memread), .ex_memwrite(ex_memwrite),
      .ex_regwrite(ex_regwrite), .ex_memtoreg(ex_memtoreg), .stall_cnt(stall_cnt)
   );

   id_ex_stage #(.CNTW(4)) dut_s (
      .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc4(id_pc4), .id_instru(id_instru),
      .id_read1(id_read1), .id_read2(id_read2), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
      .id_ctrl(id_ctrl), .id_uses_rt(id_uses_rt), .flush(flush),
      .mem_regwrite(mem_regwrite), .mem_rd(mem_rd), .mem_result(mem_result),
      .wb_regwrite(wb_regwrite), .wb_rd(wb_rd), .wb_data(wb_data),
      .stall_o(s_stall_o), .ex_valid(s_ex_valid), .ex_pc4(s_ex_pc4), .ex_instru(s_ex_instru),
      .ex_data1(s_ex_data1), .ex_read2(s_ex_read2), .ex_alusrc(s_ex_alusrc), .ex_alucontrol(s_ex_alucontrol),
      .ex_writereg(s_ex_writereg), .ex_memread(s_ex_memread), .ex_memwrite(s_ex_memwrite),
      .ex_regwrite(s_ex_regwrite), .ex_memtoreg(s_ex_memtoreg), .stall_cnt(s_stall_cnt)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s step=%0d actual=%0h expected=%0h", name, tag, act, exp);
      end
   endtask

   // ---------------- behavioural model of the EX slot ----------------
   typedef struct {
      logic        valid;
      logic [31:0] pc4, instru, read1, read2;
      logic [4:0]  rs, rt, wreg;
      logic        alusrc;
      logic [3:0]  aluc;
      logic        memread, memwrite, regwrite, memtoreg;
   } ex_t;

   ex_t m;
   int  cnt16, cnt4;
   logic last_st;

   function automatic ex_t zero_slot();
      ex_t z;
      z.valid = 0; z.pc4 = 0; z.instru = 0; z.read1 = 0; z.read2 = 0;
      z.rs = 0; z.rt = 0; z.wreg = 0; z.alusrc = 0; z.aluc = 0;
      z.memread = 0; z.memwrite = 0; z.regwrite = 0; z.memtoreg = 0;
      return z;
   endfunction

   task automatic model_reset();
      m = zero_slot();
      cnt16 = 0;
      cnt4 = 0;
      last_st = 0;
   endtask

   function automatic logic model_stall();
      return m.valid && m.memread && m.wreg != 0 && id_valid &&
             (m.wreg == id_rs || (id_uses_rt && m.wreg == id_rt));
   endfunction

   function automatic logic [31:0] model_fwd(input logic [4:0] r, input logic [31:0] v);
      if (mem_regwrite && mem_rd != 0 && mem_rd == r) return mem_result;
      if (wb_regwrite && wb_rd != 0 && wb_rd == r) return wb_data;
      return v;
   endfunction

   task automatic model_edge(input logic st);
      if (flush || st) begin
         m = zero_slot();
         m.aluc = 4'b0010;
      end else begin
         m.valid = id_valid; m.pc4 = id_pc4; m.instru = id_instru;
         m.read1 = id_read1; m.read2 = id_read2; m.rs = id_rs; m.rt = id_rt;
         if (id_valid) begin
            m.alusrc = id_ctrl[9]; m.aluc = id_ctrl[8:5];
            m.wreg = id_ctrl[4] ? id_rd : id_rt;
            m.memread = id_ctrl[3]; m.memwrite = id_ctrl[2];
            m.regwrite = id_ctrl[1]; m.memtoreg = id_ctrl[0];
         end else begin
            m.alusrc = 0; m.aluc = 0; m.wreg = 0;
            m.memread = 0; m.memwrite = 0; m.regwrite = 0; m.memtoreg = 0;
         end
      end
      if (st && !flush) begin
         if (cnt16 < 65535) cnt16++;
         if (cnt4 < 15) cnt4++;
      end
   endtask

   // One clock with model comparison; inputs were driven after the falling edge.
   task automatic model_cycle();
      logic st;
      #1;
      st = model_stall();
      check("m_stall", {31'd0, stall_o}, {31'd0, st});
      check("m_fwd1_pre", ex_data1, model_fwd(m.rs, m.read1));
      check("m_fwd2_pre", ex_read2, model_fwd(m.rt, m.read2));
      @(posedge clk);
      model_edge(st);
      last_st = st;
      #1;
      check("m_valid", {31'd0, ex_valid}, {31'd0, m.valid});
      check("m_pc4", ex_pc4, m.pc4);
      check("m_instru", ex_instru, m.instru);
      check("m_ctrl", {25'd0, ex_alusrc, ex_alucontrol, ex_memread, ex_memwrite, ex_regwrite, ex_memtoreg},
            {25'd0, m.alusrc, m.aluc, m.memread, m.memwrite, m.regwrite, m.memtoreg});
      check("m_wreg", {27'd0, ex_writereg}, {27'd0, m.wreg});
      check("m_data1", ex_data1, model_fwd(m.rs, m.read1));
      check("m_read2", ex_read2, model_fwd(m.rt, m.read2));
      check("m_cnt16", {16'd0, stall_cnt}, cnt16);
      check("m_cnt4", {28'd0, s_stall_cnt}, cnt4);
      @(negedge clk);
      tag++;
   endtask

   // ---------------- drivers ----------------
   task automatic drive_id(input logic v, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                           input logic [9:0] ctrl, input logic ur, input logic [31:0] r1, input logic [31:0] r2);
      id_valid = v; id_rs = rs; id_rt = rt; id_rd = rd; id_ctrl = ctrl; id_uses_rt = ur;
      id_read1 = r1; id_read2 = r2;
      id_instru = {6'd0, rs, rt, rd, 5'd0, 6'h20};
      id_pc4 = 32'h400 + {r1[7:0], 2'b00};
   endtask

   task automatic drive_fwd(input logic mrw, input logic [4:0] mrd, input logic [31:0] mres,
                            input logic wrw, input logic [4:0] wrd, input logic [31:0] wdat);
      mem_regwrite = mrw; mem_rd = mrd; mem_result = mres;
      wb_regwrite = wrw; wb_rd = wrd; wb_data = wdat;
   endtask

   // ---------------- directed vector table ----------------
   typedef struct {
      logic v; logic [4:0] rs, rt, rd; logic [9:0] ctrl; logic ur; logic [31:0] r1, r2; logic fl;
      logic mrw; logic [4:0] mrd; logic [31:0] mres; logic wrw; logic [4:0] wrd; logic [31:0] wdat;
      logic e_stall, e_valid; logic [31:0] e_d1, e_r2; logic [3:0] e_aluc; logic [4:0] e_wreg;
      logic e_regw, e_mrd; logic [15:0] e_cnt;
   } vec_t;

   vec_t vt[14];

   task automatic apply_vec(input vec_t v);
      drive_id(v.v, v.rs, v.rt, v.rd, v.ctrl, v.ur, v.r1, v.r2);
      flush = v.fl;
      drive_fwd(v.mrw, v.mrd, v.mres, v.wrw, v.wrd, v.wdat);
      #1;
      check("v_stall", {31'd0, stall_o}, {31'd0, v.e_stall});
      @(posedge clk);
      #1;
      check("v_valid", {31'd0, ex_valid}, {31'd0, v.e_valid});
      check("v_data1", ex_data1, v.e_d1);
      check("v_read2", ex_read2, v.e_r2);
      check("v_aluc", {28'd0, ex_alucontrol}, {28'd0, v.e_aluc});
      check("v_wreg", {27'd0, ex_writereg}, {27'd0, v.e_wreg});
      check("v_regw", {31'd0, ex_regwrite}, {31'd0, v.e_regw});
      check("v_memread", {31'd0, ex_memread}, {31'd0, v.e_mrd});
      check("v_cnt", {16'd0, stall_cnt}, {16'd0, v.e_cnt});
      @(negedge clk);
      tag++;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog step=%0d actual=timeout expected=finish", tag);
      $fatal(1, "watchdog");
   end

   initial begin
      //          v rs rt rd ctrl   ur r1   r2  fl mrw mrd mres   wrw wrd wdat   st vl d1     r2     alu wr rw mr cnt
      vt[0]  = '{1, 1, 2, 3, C_ADD, 1, 5,   7,  0, 0,  0, 0,     0,  0, 0,     0, 1, 5,     7,     2,  3, 1, 0, 0};
      vt[1]  = '{1, 1, 2, 6, C_ADD, 1, 9,   8,  0, 1,  1, 'h10,  1,  1, 'h20,  0, 1, 'h10,  8,     2,  6, 1, 0, 0};
      vt[2]  = '{1, 1, 2, 6, C_ADD, 1, 9,   8,  0, 1,  4, 'h10,  1,  1, 'h20,  0, 1, 'h20,  8,     2,  6, 1, 0, 0};
      vt[3]  = '{1, 1, 2, 6, C_ADD, 1, 9,   8,  0, 1,  0, 'h10,  1,  0, 'h20,  0, 1, 9,     8,     2,  6, 1, 0, 0};
      vt[4]  = '{1, 2, 1, 7, C_ADD, 1, 11,  12, 0, 1,  1, 'h10,  0,  0, 0,     0, 1, 11,    'h10,  2,  7, 1, 0, 0};
      vt[5]  = '{1, 1, 4, 0, C_LW,  0, 100, 0,  0, 0,  0, 0,     0,  0, 0,     0, 1, 100,   0,     2,  4, 1, 1, 0};
      vt[6]  = '{1, 4, 4, 5, C_ADD, 1, 1,   1,  0, 0,  0, 0,     0,  0, 0,     1, 0, 0,     0,     2,  0, 0, 0, 1};
      vt[7]  = '{1, 4, 4, 5, C_ADD, 1, 1,   1,  0, 0,  0, 0,     1,  4, 'h77,  0, 1, 'h77,  'h77,  2,  5, 1, 0, 1};
      vt[8]  = '{1, 1, 4, 0, C_LW,  0, 200, 0,  0, 0,  0, 0,     0,  0, 0,     0, 1, 200,   0,     2,  4, 1, 1, 1};
      vt[9]  = '{1, 4, 4, 5, C_ADD, 1, 1,   1,  1, 0,  0, 0,     0,  0, 0,     1, 0, 0,     0,     2,  0, 0, 0, 1};
      vt[10] = '{1, 4, 4, 5, C_ADD, 1, 1,   1,  1, 0,  0, 0,     0,  0, 0,     0, 0, 0,     0,     2,  0, 0, 0, 1};
      vt[11] = '{0, 0, 0, 0, C_ADD, 1, 33,  44, 0, 1,  0, 'h55,  0,  0, 0,     0, 0, 33,    44,    0,  0, 0, 0, 1};
      vt[12] = '{1, 1, 4, 0, C_LW,  0, 300, 0,  0, 0,  0, 0,     0,  0, 0,     0, 1, 300,   0,     2,  4, 1, 1, 1};
      vt[13] = '{1, 2, 4, 0, C_ADDI,0, 50,  60, 0, 0,  0, 0,     0,  0, 0,     0, 1, 50,    60,    2,  4, 1, 0, 1};

      rst_n = 1'b0;
      flush = 1'b0;
      drive_id(0, 0, 0, 0, 10'd0, 0, 0, 0);
      drive_fwd(0, 0, 0, 0, 0, 0);
      model_reset();
      repeat (2) @(negedge clk);
      check("rst_valid", {31'd0, ex_valid}, 32'd0);
      check("rst_aluc", {28'd0, ex_alucontrol}, 32'd0);
      check("rst_cnt", {16'd0, stall_cnt}, 32'd0);
      rst_n = 1'b1;

      for (int i = 0; i < 14; i++) apply_vec(vt[i]);

      // Asynchronous reset mid-run with a live instruction in EX.
      drive_id(1, 1, 4, 0, C_LW, 0, 400, 0);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_valid", {31'd0, ex_valid}, 32'd0);
      check("arst_pc4", ex_pc4, 32'd0);
      check("arst_instru", ex_instru, 32'd0);
      check("arst_data1", ex_data1, 32'd0);
      check("arst_read2", ex_read2, 32'd0);
      check("arst_ctrl", {25'd0, ex_alusrc, ex_alucontrol, ex_memread, ex_memwrite, ex_regwrite, ex_memtoreg}, 32'd0);
      check("arst_wreg", {27'd0, ex_writereg}, 32'd0);
      check("arst_cnt", {16'd0, stall_cnt}, 32'd0);
      model_reset();
      @(negedge clk);
      rst_n = 1'b1;

      // Twenty load-use pairs: the 4-bit counter must saturate.
      drive_fwd(0, 0, 0, 0, 0, 0);
      for (int i = 0; i < 20; i++) begin
         drive_id(1, 1, 4, 0, C_LW, 0, i, 0);
         model_cycle();
         drive_id(1, 4, 4, 5, C_ADD, 1, 3, 3);
         model_cycle();
         model_cycle();
      end
      check("sat_cnt4", {28'd0, s_stall_cnt}, 32'd15);
      check("sat_cnt16", {16'd0, stall_cnt}, 32'd20);

      // Randomized traffic; a stalled ID instruction is re-presented unchanged.
      for (int i = 0; i < 600; i++) begin
         if (!last_st) begin
            drive_id(1'($urandom_range(0, 5) != 0), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                     5'($urandom_range(0, 7)), 10'($urandom), 1'($urandom_range(0, 1)), $urandom, $urandom);
            id_pc4 = $urandom;
            id_instru = $urandom;
         end
         flush = ($urandom_range(0, 9) == 0);
         drive_fwd(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
                   1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom);
         model_cycle();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
